// File: rtl/dma_fifo_pkg.sv
// Shared definitions for the DMA FIFO sequencer.
//   state_t     : sequencer states (IDLE, RUN, FLUSH, DONE)
//   DIR_DEV2MEM : device -> memory transfer direction
//   DIR_MEM2DEV : memory -> device transfer direction
package dma_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic DIR_DEV2MEM = 1'b0;
    localparam logic DIR_MEM2DEV = 1'b1;

endpackage

// File: rtl/dma_fifo_ctrl.sv
// Sequencer moving a programmed block of words between a device port and the
// chip-bus DMA slot through an external single-clock FIFO owned by the parent.
// It drives the FIFO enables, tracks FIFO occupancy and word counts, requests
// DMA slots, flushes on abort and pulses done_irq on completion. All state
// advances only on clk7_en.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   clk7_en                  : 7 MHz clock enable
//   cfg_start/dir/len/abort  : transfer programming and abort
//   busy, done_irq           : status (busy outside IDLE, completion pulse)
//   dev_valid/wdata/ready    : device -> FIFO write handshake (dir 0)
//   dev_rreq/rdata/rvalid    : FIFO -> device pop handshake (dir 1)
//   dma_req/ack/wdata/rdata  : chip-bus DMA slot interface
//   fifo_in/wr_en/rd_en/out/full/empty : attached FIFO
module dma_fifo_ctrl
    import dma_fifo_pkg::*;
#(
    parameter int FD  = 16,
    parameter int DW  = 16,
    parameter int LW  = 14,
    parameter int THR = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk7_en,
    input  logic          cfg_start,
    input  logic          cfg_dir,
    input  logic [LW-1:0] cfg_len,
    input  logic          cfg_abort,
    output logic          busy,
    output logic          done_irq,
    input  logic          dev_valid,
    input  logic [DW-1:0] dev_wdata,
    output logic          dev_ready,
    input  logic          dev_rreq,
    output logic [DW-1:0] dev_rdata,
    output logic          dev_rvalid,
    output logic          dma_req,
    input  logic          dma_ack,
    output logic [DW-1:0] dma_wdata,
    input  logic [DW-1:0] dma_rdata,
    output logic [DW-1:0] fifo_in,
    output logic          fifo_wr_en,
    output logic          fifo_rd_en,
    input  logic [DW-1:0] fifo_out,
    input  logic          fifo_full,
    input  logic          fifo_empty
);

    localparam int LVLW = $clog2(FD) + 1;
    localparam int CW   = LW + LVLW;

    state_t          state;
    logic            dir_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   in_cnt;
    logic [LW-1:0]   out_cnt;
    logic [LVLW-1:0] lvl;
    logic            dma_req_q;

    logic            run_ok;
    logic            dev2mem;
    logic            in_left;
    logic            dev_wr;
    logic            dma_rd;
    logic            dma_wr;
    logic            dev_rd;
    logic            flush_rd;
    logic            wr_any;
    logic            rd_any;
    logic            out_rd;
    logic [LW-1:0]   in_nxt;
    logic [LW-1:0]   out_nxt;
    logic [LVLW-1:0] lvl_nxt;
    logic [LVLW-1:0] space;
    logic [LW-1:0]   rem;
    logic            req_d2m;
    logic            req_m2d;

    // Abort blocks every data movement in the cycle it is seen.
    assign run_ok  = (state == RUN) & clk7_en & ~cfg_abort;
    assign dev2mem = (dir_q == DIR_DEV2MEM);
    assign in_left = (in_cnt < len_q);

    // dma_ack is honoured only while our registered request is up; the
    // full/empty guards cover the extra grant allowed by the request lag.
    assign dev_wr   = run_ok & dev2mem & dev_valid & ~fifo_full & in_left;
    assign dma_rd   = run_ok & dev2mem & dma_req_q & dma_ack & ~fifo_empty;
    assign dma_wr   = run_ok & ~dev2mem & dma_req_q & dma_ack & ~fifo_full & in_left;
    assign dev_rd   = run_ok & ~dev2mem & dev_rreq & ~fifo_empty;
    assign flush_rd = (state == FLUSH) & clk7_en & ~fifo_empty;

    assign wr_any = dev_wr | dma_wr;
    assign out_rd = dma_rd | dev_rd;
    assign rd_any = out_rd | flush_rd;

    assign fifo_wr_en = wr_any;
    assign fifo_rd_en = rd_any;
    assign fifo_in    = dev2mem ? dev_wdata : dma_rdata;
    assign dev_ready  = dev_wr;
    assign dev_rvalid = dev_rd;
    assign dev_rdata  = fifo_out;
    assign dma_wdata  = fifo_out;
    assign dma_req    = dma_req_q;

    assign busy     = (state != IDLE);
    assign done_irq = (state == DONE);

    assign in_nxt  = in_cnt + LW'(wr_any);
    assign out_nxt = out_cnt + LW'(out_rd);

    always_comb begin
        lvl_nxt = lvl;
        case ({wr_any, rd_any})
            2'b10:   lvl_nxt = lvl + LVLW'(1);
            2'b01:   lvl_nxt = lvl - LVLW'(1);
            default: lvl_nxt = lvl;
        endcase
    end

    // Request conditions use the current (pre-edge) occupancy and counts, so
    // dma_req follows its condition one enable cycle late.
    assign space   = LVLW'(FD) - lvl;
    assign rem     = len_q - in_cnt;
    assign req_d2m = (lvl >= LVLW'(THR)) | ((in_cnt == len_q) & (lvl != '0));
    assign req_m2d = ((space >= LVLW'(THR)) | (CW'(space) >= CW'(rem)))
                     & in_left & ~fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dir_q     <= DIR_DEV2MEM;
            len_q     <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            lvl       <= '0;
            dma_req_q <= 1'b0;
        end else if (clk7_en) begin
            lvl <= lvl_nxt;
            case (state)
                IDLE: begin
                    dma_req_q <= 1'b0;
                    if (cfg_start) begin
                        dir_q   <= cfg_dir;
                        len_q   <= cfg_len;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        lvl     <= '0;
                        state   <= (cfg_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (cfg_abort) begin
                        state     <= FLUSH;
                        dma_req_q <= 1'b0;
                    end else begin
                        in_cnt  <= in_nxt;
                        out_cnt <= out_nxt;
                        // Leave on the edge that retires the last word so
                        // done_irq shows in the very next enable cycle.
                        if (out_nxt == len_q) begin
                            state     <= DONE;
                            dma_req_q <= 1'b0;
                        end else begin
                            dma_req_q <= dev2mem ? req_d2m : req_m2d;
                        end
                    end
                end
                FLUSH: begin
                    dma_req_q <= 1'b0;
                    if (fifo_empty) state <= IDLE;
                end
                DONE: begin
                    dma_req_q <= 1'b0;
                    state     <= cfg_abort ? FLUSH : IDLE;
                end
                default: begin
                    state     <= IDLE;
                    dma_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_fifo_ctrl.sv
// Bench for dma_fifo_ctrl: a behavioural FIFO sits beside the DUT, a table of
// hand-computed vectors covers the main transfer shapes, and short scripted
// sequences cover the stall, ignore and clock-enable corner cases.
module tb_dma_fifo_ctrl;

    localparam int FD  = 16;
    localparam int DW  = 16;
    localparam int LW  = 14;
    localparam int THR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk7_en;
    logic          cfg_start;
    logic          cfg_dir;
    logic [LW-1:0] cfg_len;
    logic          cfg_abort;
    logic          busy;
    logic          done_irq;
    logic          dev_valid;
    logic [DW-1:0] dev_wdata;
    logic          dev_ready;
    logic          dev_rreq;
    logic [DW-1:0] dev_rdata;
    logic          dev_rvalid;
    logic          dma_req;
    logic          dma_ack;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic [DW-1:0] fifo_in;
    logic          fifo_wr_en;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_out;
    logic          fifo_full;
    logic          fifo_empty;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dma_fifo_ctrl #(.FD(FD), .DW(DW), .LW(LW), .THR(THR)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk7_en    (clk7_en),
        .cfg_start  (cfg_start),
        .cfg_dir    (cfg_dir),
        .cfg_len    (cfg_len),
        .cfg_abort  (cfg_abort),
        .busy       (busy),
        .done_irq   (done_irq),
        .dev_valid  (dev_valid),
        .dev_wdata  (dev_wdata),
        .dev_ready  (dev_ready),
        .dev_rreq   (dev_rreq),
        .dev_rdata  (dev_rdata),
        .dev_rvalid (dev_rvalid),
        .dma_req    (dma_req),
        .dma_ack    (dma_ack),
        .dma_wdata  (dma_wdata),
        .dma_rdata  (dma_rdata),
        .fifo_in    (fifo_in),
        .fifo_wr_en (fifo_wr_en),
        .fifo_rd_en (fifo_rd_en),
        .fifo_out   (fifo_out),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    // Behavioural FIFO, depth 16, flags overflow/underflow.
    logic [DW-1:0] fmem [FD];
    logic [3:0]    wp, rp;
    int            fcnt;
    logic          ovf, unf;

    assign fifo_full  = (fcnt == FD);
    assign fifo_empty = (fcnt == 0);
    assign fifo_out   = fmem[rp];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= 0;
            wp   <= 4'd0;
            rp   <= 4'd0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            if (fifo_wr_en) begin
                if (fcnt == FD) ovf <= 1'b1;
                else begin
                    fmem[wp] <= fifo_in;
                    wp       <= wp + 4'd1;
                end
            end
            if (fifo_rd_en) begin
                if (fcnt == 0) unf <= 1'b1;
                else rp <= rp + 4'd1;
            end
            fcnt <= fcnt + ((fifo_wr_en && fcnt < FD) ? 1 : 0)
                         - ((fifo_rd_en && fcnt > 0) ? 1 : 0);
        end
    end

    // {busy, done_irq, dma_req, dev_ready, fifo_wr_en, fifo_rd_en, dev_rvalid}
    logic [6:0] outs;
    assign outs = {busy, done_irq, dma_req, dev_ready, fifo_wr_en, fifo_rd_en, dev_rvalid};

    typedef struct {
        logic          start;
        logic          dir;
        logic [LW-1:0] len;
        logic          abort;
        logic          dv;
        logic          ack;
        logic          rreq;
        logic [DW-1:0] din;
        logic [6:0]    exp;
        int            dsel;   // 0 none, 1 dma_wdata, 2 dev_rdata
        logic [DW-1:0] dexp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic dr, input int ln,
                                input logic ab, input logic dv, input logic ak,
                                input logic rq, input logic [DW-1:0] din,
                                input logic [6:0] ex, input int ds,
                                input logic [DW-1:0] dx);
        vec_t v;
        v.start = st;  v.dir = dr;  v.len = LW'(ln);  v.abort = ab;
        v.dv = dv;  v.ack = ak;  v.rreq = rq;  v.din = din;
        v.exp = ex;  v.dsel = ds;  v.dexp = dx;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        clk7_en   = 1'b1;
        cfg_start = 1'b0;
        cfg_dir   = 1'b0;
        cfg_len   = '0;
        cfg_abort = 1'b0;
        dev_valid = 1'b0;
        dev_wdata = '0;
        dev_rreq  = 1'b0;
        dma_ack   = 1'b0;
        dma_rdata = '0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        clk7_en   = 1'b1;
        cfg_start = v.start;
        cfg_dir   = v.dir;
        cfg_len   = v.len;
        cfg_abort = v.abort;
        dev_valid = v.dv;
        dma_ack   = v.ack;
        dev_rreq  = v.rreq;
        dev_wdata = v.din;
        dma_rdata = v.din;
        #1;
        chk($sformatf("vec%0d outs", idx), 32'(outs), 32'(v.exp));
        if (v.dsel == 1) chk($sformatf("vec%0d dma_wdata", idx), 32'(dma_wdata), 32'(v.dexp));
        if (v.dsel == 2) chk($sformatf("vec%0d dev_rdata", idx), 32'(dev_rdata), 32'(v.dexp));
    endtask

    int  sent, got, acc;
    bit  seen;

    initial begin
        // dir 0, len 6: request rises once four words sit in the FIFO
        vecs.push_back(mk(1,0,6, 0,0,0,0, 16'h0000, 7'b0000000, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 16'hA001, 7'b1001100, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 16'hA002, 7'b1001100, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 16'hA003, 7'b1001100, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 16'hA004, 7'b1001100, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 16'hA005, 7'b1001100, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 16'hA006, 7'b1011100, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,1,1,0, 16'hBEEF, 7'b1010010, 1, 16'hA001));
        vecs.push_back(mk(0,0,0, 0,0,1,0, 16'h0000, 7'b1010010, 1, 16'hA002));
        vecs.push_back(mk(0,0,0, 0,0,1,0, 16'h0000, 7'b1010010, 1, 16'hA003));
        vecs.push_back(mk(0,0,0, 0,0,1,0, 16'h0000, 7'b1010010, 1, 16'hA004));
        vecs.push_back(mk(0,0,0, 0,0,1,0, 16'h0000, 7'b1010010, 1, 16'hA005));
        vecs.push_back(mk(0,0,0, 0,0,1,0, 16'h0000, 7'b1010010, 1, 16'hA006));
        vecs.push_back(mk(0,0,0, 0,0,1,0, 16'h0000, 7'b1100000, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,0,0,0, 16'h0000, 7'b0000000, 0, 16'h0));
        // dir 1, len 5: device pops each cycle
        vecs.push_back(mk(1,1,5, 0,0,0,0, 16'h0000, 7'b0000000, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,0,0,0, 16'h0000, 7'b1000000, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,0,1,1, 16'hB001, 7'b1010100, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,0,1,1, 16'hB002, 7'b1010111, 2, 16'hB001));
        vecs.push_back(mk(0,0,0, 0,0,1,1, 16'hB003, 7'b1010111, 2, 16'hB002));
        vecs.push_back(mk(0,0,0, 0,0,1,1, 16'hB004, 7'b1010111, 2, 16'hB003));
        vecs.push_back(mk(0,0,0, 0,0,1,1, 16'hB005, 7'b1010111, 2, 16'hB004));
        vecs.push_back(mk(0,0,0, 0,0,1,1, 16'h5555, 7'b1010011, 2, 16'hB005));
        vecs.push_back(mk(0,0,0, 0,0,1,1, 16'h0000, 7'b1100000, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,0,0,0, 16'h0000, 7'b0000000, 0, 16'h0));
        // zero-length start
        vecs.push_back(mk(1,0,0, 0,0,0,0, 16'h0000, 7'b0000000, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 16'h1234, 7'b1100000, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,0,0,0, 16'h0000, 7'b0000000, 0, 16'h0));
        // abort with three words buffered
        vecs.push_back(mk(1,0,10,0,0,0,0, 16'h0000, 7'b0000000, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 16'hC001, 7'b1001100, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 16'hC002, 7'b1001100, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 16'hC003, 7'b1001100, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 1,1,1,0, 16'hC004, 7'b1000000, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 16'hC005, 7'b1000010, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 16'hC005, 7'b1000010, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,1,0,0, 16'hC005, 7'b1000010, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,0,0,0, 16'h0000, 7'b1000000, 0, 16'h0));
        vecs.push_back(mk(0,0,0, 0,0,0,0, 16'h0000, 7'b0000000, 0, 16'h0));

        // Reset: every control output low even with requests pending.
        idle_in();
        rst       = 1'b1;
        dev_valid = 1'b1;
        dma_ack   = 1'b1;
        dev_rreq  = 1'b1;
        @(negedge clk);
        #1;
        chk("reset outs", 32'(outs), 32'h0);
        @(negedge clk);
        idle_in();
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
        chk("table fifo drained", 32'(fcnt), 32'd0);

        // Stalled DMA, len 20: device fills the FIFO and is then held off.
        @(negedge clk);
        idle_in();
        cfg_start = 1'b1;
        cfg_len   = LW'(20);
        sent = 0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            dev_valid = 1'b1;
            dev_wdata = 16'hD000 + 16'(sent);
            #1;
            chk($sformatf("stall ready %0d", k), 32'(dev_ready), (k < 16) ? 32'd1 : 32'd0);
            if (dev_ready) sent++;
        end
        chk("stall fill level", 32'(fcnt), 32'd16);
        got  = 0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            dev_valid = (sent < 20);
            dev_wdata = 16'hD000 + 16'(sent);
            dma_ack   = 1'b1;
            #1;
            if (dev_ready) sent++;
            if (fifo_rd_en) begin
                chk($sformatf("stall word %0d", got), 32'(dma_wdata), 32'(16'hD000 + 16'(got)));
                got++;
            end
            if (done_irq) seen = 1'b1;
        end
        chk("stall done seen", 32'(seen), 32'd1);
        chk("stall word count", 32'(got), 32'd20);
        @(negedge clk);
        idle_in();
        #1;
        chk("stall back idle", 32'(busy), 32'd0);
        chk("stall fifo empty", 32'(fcnt), 32'd0);

        // Ignored start / stray ack / enable freeze, len 6 in dir 0.
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_len   = LW'(6);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            dev_valid = 1'b1;
            dev_wdata = 16'hE001 + 16'(k);
            #1;
            chk($sformatf("ign push %0d", k), 32'(dev_ready), 32'd1);
        end
        @(negedge clk);
        dev_valid = 1'b0;
        cfg_start = 1'b1;
        cfg_dir   = 1'b1;
        cfg_len   = LW'(3);
        dma_ack   = 1'b1;
        dma_rdata = 16'h7777;
        #1;
        chk("ign busy", 32'(busy), 32'd1);
        chk("ign stray ack rd", 32'(fifo_rd_en), 32'd0);
        chk("ign stray ack wr", 32'(fifo_wr_en), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            clk7_en   = 1'b0;
            dev_valid = 1'b1;
            dev_wdata = 16'hEEEE;
            #1;
            chk($sformatf("freeze wr %0d", k), 32'(fifo_wr_en), 32'd0);
            chk($sformatf("freeze rd %0d", k), 32'(fifo_rd_en), 32'd0);
        end
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            clk7_en   = 1'b1;
            cfg_start = 1'b0;
            cfg_dir   = 1'b0;
            cfg_len   = '0;
            dma_ack   = 1'b0;
            dev_valid = 1'b1;
            dev_wdata = 16'hE003 + 16'(acc);
            #1;
            if (dev_ready) acc++;
        end
        chk("ign remaining words", 32'(acc), 32'd4);
        chk("ign fifo level", 32'(fcnt), 32'd6);
        @(negedge clk);
        dev_valid = 1'b0;
        cfg_abort = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            cfg_abort = 1'b0;
            #1;
            chk($sformatf("abort no irq %0d", k), 32'(done_irq), 32'd0);
            if (!busy) seen = 1'b1;
        end
        chk("abort reached idle", 32'(seen), 32'd1);
        chk("abort fifo empty", 32'(fcnt), 32'd0);

        // done_irq held while clk7_en is low.
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_len   = '0;
        @(negedge clk);
        cfg_start = 1'b0;
        clk7_en   = 1'b0;
        #1;
        chk("freeze done a", 32'(done_irq), 32'd1);
        @(negedge clk);
        #1;
        chk("freeze done b", 32'(done_irq), 32'd1);
        @(negedge clk);
        clk7_en = 1'b1;
        #1;
        chk("freeze done c", 32'(done_irq), 32'd1);
        @(negedge clk);
        #1;
        chk("freeze done end", 32'(outs), 32'h0);

        chk("fifo overflow", 32'(ovf), 32'd0);
        chk("fifo underflow", 32'(unf), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_fifo_ctrl.md
# dma_fifo_ctrl

Sequencer that moves a programmed block of words between a device port and the chip-bus DMA slot through a single-clock FIFO instantiated beside it in the parent. It owns the FIFO's write/read enables, tracks fill level and word counts, requests DMA slots, flushes on abort and raises a completion pulse. It sits between the disk/serial shifters and the chip-bus DMA scheduler. All state advances only on `clk7_en`.

## Interface
- `FD`, 16: FIFO depth (power of two, ≥2); must match the attached FIFO.
- `DW`, 16: data width.
- `LW`, 14: length-counter width.
- `THR`, 4: fill/space threshold for a DMA request (1..FD).

- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous and active-high.
- `clk7_en` in 1: 7 MHz clock enable.
- `cfg_start` in 1: start pulse; sampled in IDLE only.
- `cfg_dir` in 1: 0 = device→memory, 1 = memory→device; latched at start.
- `cfg_len` in LW: word count; latched at start.
- `cfg_abort` in 1: abort the transfer, any state.
- `busy` out 1: high in every state except IDLE.
- `done_irq` out 1: one-enable-cycle completion pulse.
- `dev_valid` in 1: device offers `dev_wdata` (dir 0).
- `dev_wdata` in DW: device write data.
- `dev_ready` out 1: the offered word is accepted this enable cycle.
- `dev_rreq` in 1: device pops a word (dir 1).
- `dev_rdata` out DW: FIFO head.
- `dev_rvalid` out 1: the pop is honoured.
- `dma_req` out 1: DMA slot request (registered).
- `dma_ack` in 1: slot granted this enable cycle; data moves the same cycle.
- `dma_wdata` out DW: FIFO head to memory.
- `dma_rdata` in DW: memory data.
- `fifo_in` out DW: FIFO write data.
- `fifo_wr_en` out 1: FIFO write enable.
- `fifo_rd_en` out 1: FIFO read enable.
- `fifo_out` in DW: FIFO head.
- `fifo_full` in 1: FIFO full flag.
- `fifo_empty` in 1: FIFO empty flag.

## Operation
- Registers: `len_q` (LW), `in_cnt`/`out_cnt` (LW, words written into / read out of the FIFO), `lvl` (clog2(FD)+1, 0..FD), `dir_q`.
- `lvl` tracks FIFO occupancy. It increments on a write-only enable cycle, decrements on a read-only one, and holds on both or neither. It must always equal the FIFO's internal count.
- States and transitions:
  - IDLE → RUN on `cfg_start`; clears all counters and latches `cfg_len` and `cfg_dir`.
  - If `cfg_len`=0, IDLE → DONE instead.
  - RUN, dir 0:
    - Device write when `dev_valid & ~fifo_full & in_cnt<len_q`. `dev_ready = fifo_wr_en` and `fifo_in = dev_wdata` (combinational).
    - `dma_req` next cycle = `(lvl≥THR) | (in_cnt==len_q & lvl≠0)`.
    - On `dma_ack & ~fifo_empty`: `fifo_rd_en`, with `dma_wdata = fifo_out`.
  - RUN, dir 1:
    - `dma_req` next cycle = `(FD−lvl≥THR | FD−lvl ≥ len_q−in_cnt) & in_cnt<len_q & ~fifo_full`.
    - On `dma_ack & ~fifo_full`: `fifo_wr_en`, with `fifo_in = dma_rdata`.
    - Device pop when `dev_rreq & ~fifo_empty`: `dev_rvalid = fifo_rd_en`.
  - RUN → DONE when `out_cnt==len_q`.
  - DONE: `done_irq`=1 for one enable cycle → IDLE.
  - Any state except IDLE → FLUSH on `cfg_abort`. Abort has priority over every other event that cycle, and no data moves that cycle.
  - FLUSH: `fifo_rd_en=~fifo_empty` each enable cycle; `dma_req`=0 and `dev_ready`=0. → IDLE when `fifo_empty`, with no `done_irq`.
- `dma_ack` while `dma_req`=0 or not in RUN is ignored.
- `cfg_start` outside IDLE is ignored.
- Counters never exceed `len_q`; the largest transfer is 2^LW−1 words.
- Simultaneous FIFO read and write in the same enable cycle is legal.

## Timing
- Reset values: IDLE, all counters 0, and every output 0 (`busy`, `done_irq`, `dma_req`, `dev_ready`, `dev_rvalid`, `fifo_wr_en`, `fifo_rd_en`). Data outputs are pass-through.
- `fifo_wr_en`, `fifo_rd_en`, `dev_ready`, `dev_rvalid`: combinational, qualified by `clk7_en`.
- `dma_req`: updates one enable cycle after its condition changes. Its deassertion lags by one cycle, so any extra `dma_ack` is guarded by the full/empty flags.
- Start→`busy`: next enable cycle.
- Last word out→`done_irq`: next enable cycle; `busy` drops one cycle later.

## Structure
- Package `dma_fifo_pkg`: the state enum (IDLE, RUN, FLUSH, DONE) and the direction constants DIR_DEV2MEM=0 and DIR_MEM2DEV=1.
- Single module with no sub-modules; the parent instantiates the FIFO with matching `FD` and `DW`.

## Test plan
- dir 0, len 6, THR 4, device streams every cycle, `dma_ack` one cycle after each `dma_req` → `dma_req` rises at lvl 4, six words arrive in order, `done_irq` pulses once, and end state has lvl 0 and IDLE.
- dir 0, len 20, FD 16, DMA stalled → `dev_ready`=0 once lvl=16, with no FIFO overflow; releasing DMA completes all 20 words in order.
- dir 1, len 5, device pops each cycle → `dev_rdata` sequence equals the `dma_rdata` sequence, and `dma_req` drops after the 5th ack.
- `cfg_len`=0 start → `done_irq` on the next enable cycle, with no FIFO access.
- Abort in dir 0 with lvl 3 → three `fifo_rd_en` cycles in FLUSH, then IDLE, no `done_irq`, and `dma_req`=0 throughout.
- `cfg_start` while busy, and `dma_ack` with no request → both ignored, counters unchanged; `clk7_en` held low freezes all state.
